// File: rtl/ysyx_25020037_rd_arb_if.sv
// ---------------------------------------------------------------------------
// ysyx_25020037_rd_arb_if
// AXI4-Lite-style read channel bundle (AR + R) used on both sides of the
// read arbiter.
//   master modport : drives araddr/arvalid/rready, receives arready/rdata/rresp/rvalid
//   slave  modport : the mirror image
// Parameters: ADDR_W address width, DATA_W data width.
// ---------------------------------------------------------------------------
interface ysyx_25020037_rd_arb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ysyx_25020037_rd_arb.sv
// ---------------------------------------------------------------------------
// ysyx_25020037_rd_arb
// Two-master read arbiter: shares one AR/R read port between the IFU (m0)
// and the LSU (m1). One transaction at a time; the grant is held until the
// R beat completes. A watchdog aborts with a synthetic DECERR (2'b11) if the
// slave does not finish within TIMEOUT cycles of the grant.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   m0, m1       read masters (IFU, LSU), slave modport of the bundle
//   s            shared downstream read port, master modport of the bundle
//   grant        one-hot owner, bit0 = m0, bit1 = m1, 0 when idle
//   timeout_err  one-cycle pulse when the watchdog fires
//
// Optional feature: define YSYX_25020037_RD_ARB_RR_EN for round-robin
// arbitration; otherwise m1 always beats m0.
// ---------------------------------------------------------------------------
module ysyx_25020037_rd_arb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_25020037_rd_arb_if.slave         m0,
    ysyx_25020037_rd_arb_if.slave         m1,
    ysyx_25020037_rd_arb_if.master        s,
    output logic [1:0]                    grant,
    output logic                          timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StAr, StR, StErr} state_e;

    state_e            r_state, w_state_nxt;
    logic [1:0]        r_grant, w_grant_nxt;
    logic [ADDR_W-1:0] r_araddr, w_araddr_nxt;
    logic              r_arvalid, w_arvalid_nxt;
    logic              r_timeout_err, w_timeout_err_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    logic w_req;
    logic w_pick_m1;
    logic w_gnt_rready;
    logic w_fire;

    assign w_req = m0.arvalid | m1.arvalid;

`ifdef YSYX_25020037_RD_ARB_RR_EN
    // r_ptr = 1 means m1 is preferred when both request.
    logic r_ptr;

    assign w_pick_m1 = m1.arvalid & (~m0.arvalid | r_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b1;
        end else if (r_state == StIdle && w_req) begin
            r_ptr <= ~w_pick_m1;
        end
    end
`else
    assign w_pick_m1 = m1.arvalid;
`endif

    assign w_gnt_rready = r_grant[1] ? m1.rready : m0.rready;
    assign w_fire       = (TIMEOUT != 0) && (r_cnt == CntMax);

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_araddr_nxt      = r_araddr;
        w_arvalid_nxt     = r_arvalid;
        w_cnt_nxt         = r_cnt;
        w_timeout_err_nxt = 1'b0;
        m0.arready        = 1'b0;
        m1.arready        = 1'b0;
        m0.rvalid         = 1'b0;
        m1.rvalid         = 1'b0;
        m0.rdata          = {DATA_W{1'b0}};
        m1.rdata          = {DATA_W{1'b0}};
        m0.rresp          = 2'b00;
        m1.rresp          = 2'b00;
        s.rready          = 1'b0;

        unique case (r_state)
            StIdle: begin
                // Drain any late beat the slave may still emit after a timeout.
                s.rready = 1'b1;
                if (w_req) begin
                    m1.arready    = w_pick_m1;
                    m0.arready    = ~w_pick_m1;
                    w_grant_nxt   = {w_pick_m1, ~w_pick_m1};
                    w_araddr_nxt  = w_pick_m1 ? m1.araddr : m0.araddr;
                    w_arvalid_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = StAr;
                end
            end
            StAr: begin
                if (w_fire) begin
                    w_arvalid_nxt     = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = StErr;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (s.arready) begin
                        w_arvalid_nxt = 1'b0;
                        w_state_nxt   = StR;
                    end
                end
            end
            StR: begin
                s.rready = w_gnt_rready;
                if (r_grant[1]) begin
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                    m1.rvalid = s.rvalid;
                end else begin
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                    m0.rvalid = s.rvalid;
                end
                // A completing beat wins over a watchdog expiring in the same cycle.
                if (s.rvalid && w_gnt_rready) begin
                    w_grant_nxt = 2'b00;
                    w_state_nxt = StIdle;
                end else if (w_fire) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = StErr;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            StErr: begin
                s.rready = 1'b1;
                if (r_grant[1]) begin
                    m1.rvalid = 1'b1;
                    m1.rresp  = 2'b11;
                end else begin
                    m0.rvalid = 1'b1;
                    m0.rresp  = 2'b11;
                end
                if (w_gnt_rready) begin
                    w_grant_nxt = 2'b00;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        if (rst) begin
            m0.arready = 1'b0;
            m1.arready = 1'b0;
            m0.rvalid  = 1'b0;
            m1.rvalid  = 1'b0;
            s.rready   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_grant       <= 2'b00;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_araddr      <= w_araddr_nxt;
            r_arvalid     <= w_arvalid_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign s.araddr    = r_araddr;
    assign s.arvalid   = r_arvalid;
    assign grant       = r_grant;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/ysyx_25020037_rd_arb.md
Name: ysyx_25020037_rd_arb

Overview:
- Two-master read-channel arbiter sharing one AXI4-Lite-style read port (AR/R) between the instruction fetch unit (m0) and the load/store unit (m1).
- Sits between the IFU/LSU read masters and the single memory/xbar read slave.
- Grants one transaction at a time, locks the grant until the R beat completes, and returns a synthetic error if the slave never answers.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 256, cycles from grant to the R handshake before the arbiter aborts; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m0_araddr  in  ADDR_W  IFU read address.
- m0_arvalid  in  1  IFU address valid.
- m0_arready  out  1  IFU address accepted.
- m0_rdata  out  DATA_W  IFU read data.
- m0_rresp  out  2  IFU read response.
- m0_rvalid  out  1  IFU data valid.
- m0_rready  in  1  IFU data ready.
- m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_rready: LSU read master; same directions, widths and meanings as m0.
- s_araddr  out  ADDR_W  slave address.
- s_arvalid  out  1  slave address valid.
- s_arready  in  1  slave address ready.
- s_rdata  in  DATA_W  slave data.
- s_rresp  in  2  slave response.
- s_rvalid  in  1  slave data valid.
- s_rready  out  1  slave data ready.
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1; 0 when idle.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - State IDLE.
  - `s_araddr`, `grant`, `s_arvalid`, `timeout_err` = 0.
  - Watchdog counter = 0; priority pointer = m1.
  - Combinational `m*_arready`, `m*_rvalid` and `s_rready` are forced to 0 while `rst` is high.
- IDLE:
  - If any `mX_arvalid` is high, the winner's `mX_arready` = 1 combinationally in this cycle.
  - Its address is latched into `s_araddr` and `grant` is set on the clock edge; next state AR.
  - `s_rready` = 1 in IDLE so stray late slave beats are drained and discarded.
- Arbitration: with both requesting in the same cycle, m1 (LSU) wins. Only masters whose `arvalid` is high participate.
- AR:
  - `s_arvalid` = 1, `s_araddr` held stable until `s_arready` is sampled high; then next state R.
  - A master's `arvalid` dropping after acceptance has no effect.
- R:
  - `s_rdata`/`s_rresp`/`s_rvalid` are routed to the granted master; `s_rready` = the granted master's `rready`.
  - The non-granted master sees `arready` = 0 and `rvalid` = 0, and its `rdata`/`rresp` = 0.
  - When `s_rvalid && s_rready`, next state is IDLE and `grant` clears.
  - Non-OKAY `s_rresp` is passed through unchanged.
- Latency: master `arvalid` to `s_arvalid` is 1 cycle. The R beat reaches the master combinationally, with 0 added cycles. Back-to-back transactions cost 1 idle cycle between them.
- Watchdog (TIMEOUT > 0):
  - The counter clears on grant and increments every cycle in AR/R.
  - On reaching TIMEOUT-1 without an R handshake:
    - `s_arvalid` drops.
    - State ERR, with a `timeout_err` pulse.
  - ERR: the granted master gets `rvalid` = 1, `rresp` = 2'b11, `rdata` = 0, held until its `rready`; then IDLE. `s_rready` = 1 in ERR.
- Reset mid-transaction: the transaction is abandoned; all state returns to reset values on the next edge; no response is owed to either master.

Optional Feature:
- Macro `YSYX_25020037_RD_ARB_RR_EN`.
- Defined:
  - Round-robin arbitration. The 1-bit pointer names the preferred master and flips to the other master after each grant.
  - The reset pointer prefers m1.
  - Under continuous dual requests, grants alternate m1, m0, m1, …
- Undefined: fixed priority, m1 always over m0; the pointer logic is absent.

Test Plan:
- Single IFU read: m0 araddr=0x80000000; slave arready after 2 cycles, rdata=0x00000413, rresp=0 → m0 receives 0x00000413/OKAY; grant=01 throughout; m1_rvalid stays 0.
- Simultaneous m0 0x80000004 and m1 0x80001000 requests, fixed priority → m1 is served first, then m0, with 1 idle cycle between; each master receives only its own data.
- Same dual stimulus held for 4 transactions with the RR macro → grant order m1, m0, m1, m0.
- Slave never asserts rvalid, TIMEOUT=16 → `timeout_err` pulses 16 cycles after grant; master gets rresp=2'b11, rdata=0; a later stray s_rvalid in IDLE is discarded.
- Slave returns rresp=2'b10 to m1 → forwarded unchanged, grant clears, next request accepted.
- Assert rst during R with s_rvalid pending → the next cycle shows grant=0, s_arvalid=0, all m*_rvalid=0, state IDLE.
